// File: rtl/alu_seq_pkg.sv
// Package: alu_seq_pkg
//   Shared definitions for alu_cmd_sequencer: ALU opcode encodings, sequencer
//   FSM state encoding and the opcode legality helper.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;  // A + B, Overflow meaningful
  localparam logic [2:0] OP_EQ  = 3'b001;  // A == B -> all ones / all zeros
  localparam logic [2:0] OP_SHR = 3'b010;  // A >> 1
  localparam logic [2:0] OP_NEG = 3'b011;  // -B (A unused)
  localparam logic [2:0] OP_AND = 3'b100;  // A & B

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  // Opcodes above OP_AND are undefined for the ALU and must never reach it.
  function automatic logic is_legal_op(input logic [7:0] op);
    return op <= 8'(OP_AND);
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Module: alu_cmd_sequencer
//   Command-side driver for the 4-bit combinational ALU. Accepts commands on a
//   valid/ready stream, drives the ALU operand/opcode inputs and holds them for
//   SETTLE cycles, captures Out/Overflow and returns them on a valid/ready
//   response stream. Adds operand chaining (A := last good result), opcode
//   legality checking and overflow masking (only ADD reports overflow).
//
// Parameters
//   WIDTH   operand/result width (4)
//   OPW     opcode width (3)
//   SETTLE  cycles the ALU inputs are held before capture (>=1)
//
// Ports
//   clk, rst                         clock, async active-high reset
//   cmd_valid/cmd_ready              command handshake (ready only in IDLE)
//   cmd_a, cmd_b, cmd_op, cmd_chain  command fields; chain replaces A with acc
//   alu_a, alu_b, alu_op             registered ALU inputs
//   alu_out, alu_ovf                 ALU results
//   rsp_valid/rsp_ready              response handshake
//   rsp_data, rsp_ovf, rsp_err       captured result, masked overflow, illegal op
//   busy                             sequencer not in IDLE
//
// Optional feature: define ALU_SEQ_STICKY_OVF_EN to add ovf_sticky (out) and
// ovf_clr (in): a sticky flag set by any completed op reporting overflow,
// cleared by ovf_clr (set wins over a simultaneous clear).
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned OPW    = 3,
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [OPW-1:0]   cmd_op,
  input  logic             cmd_chain,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_ovf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_ovf,
  output logic             rsp_err,
`ifdef ALU_SEQ_STICKY_OVF_EN
  output logic             ovf_sticky,
  input  logic             ovf_clr,
`endif
  output logic             busy
);

  localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] acc;
  logic             cmd_legal;
  logic             accept;
  logic             capture;

  assign cmd_legal = is_legal_op(8'(cmd_op));

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          accept = 1'b1;
          if (cmd_legal) begin
            state_nxt = S_ISSUE;
            cnt_nxt   = CNT_LOAD;
          end else begin
            // Illegal opcodes answer directly; the ALU inputs stay untouched.
            state_nxt = S_RESP;
          end
        end
      end
      S_ISSUE: begin
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = S_RESP;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    cmd_ready = (state == S_IDLE);
    rsp_valid = (state == S_RESP);
    busy      = (state != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // ALU operand registers, accumulator and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      acc      <= '0;
      rsp_data <= '0;
      rsp_ovf  <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      if (accept && cmd_legal) begin
        alu_a  <= cmd_chain ? acc : cmd_a;
        alu_b  <= cmd_b;
        alu_op <= cmd_op;
      end
      if (accept && !cmd_legal) begin
        rsp_data <= '0;
        rsp_ovf  <= 1'b0;
        rsp_err  <= 1'b1;
      end
      if (capture) begin
        rsp_data <= alu_out;
        rsp_ovf  <= (alu_op == OPW'(OP_ADD)) ? alu_ovf : 1'b0;
        rsp_err  <= 1'b0;
        acc      <= alu_out;
      end
    end
  end

`ifdef ALU_SEQ_STICKY_OVF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
    end else if (capture && (alu_op == OPW'(OP_ADD)) && alu_ovf) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
module tb_alu_cmd_sequencer;

  logic       clk;
  logic       rst       [2];
  logic       cmd_valid [2];
  logic       cmd_chain [2];
  logic       rsp_ready [2];
  logic [3:0] cmd_a     [2];
  logic [3:0] cmd_b     [2];
  logic [2:0] cmd_op    [2];
  logic       cmd_ready [2];
  logic       rsp_valid [2];
  logic       rsp_ovf   [2];
  logic       rsp_err   [2];
  logic       busy      [2];
  logic       alu_ovf   [2];
  logic [3:0] alu_a     [2];
  logic [3:0] alu_b     [2];
  logic [3:0] alu_out   [2];
  logic [3:0] rsp_data  [2];
  logic [2:0] alu_op    [2];
`ifdef ALU_SEQ_STICKY_OVF_EN
  logic       ovf_sticky [2];
  logic       ovf_clr    [2];
`endif

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ALU model; EQ deliberately drives Overflow=1 so masking is visible.
  function automatic logic [4:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] op);
    logic [3:0] s;
    s = a + b;
    case (op)
      3'b000:  return {(a[3] == b[3]) && (s[3] != a[3]), s};
      3'b001:  return {1'b1, (a == b) ? 4'hF : 4'h0};
      3'b010:  return {1'b0, a >> 1};
      3'b011:  return {(b == 4'h8), 4'(-b)};
      3'b100:  return {1'b0, a & b};
      default: return {1'b1, 4'hA};
    endcase
  endfunction

  assign {alu_ovf[0], alu_out[0]} = alu_model(alu_a[0], alu_b[0], alu_op[0]);
  assign {alu_ovf[1], alu_out[1]} = alu_model(alu_a[1], alu_b[1], alu_op[1]);

  alu_cmd_sequencer #(.WIDTH(4), .OPW(3), .SETTLE(1)) u_s1 (
    .clk(clk), .rst(rst[0]),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]), .cmd_op(cmd_op[0]), .cmd_chain(cmd_chain[0]),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_op(alu_op[0]),
    .alu_out(alu_out[0]), .alu_ovf(alu_ovf[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_data(rsp_data[0]), .rsp_ovf(rsp_ovf[0]), .rsp_err(rsp_err[0]),
`ifdef ALU_SEQ_STICKY_OVF_EN
    .ovf_sticky(ovf_sticky[0]), .ovf_clr(ovf_clr[0]),
`endif
    .busy(busy[0])
  );

  alu_cmd_sequencer #(.WIDTH(4), .OPW(3), .SETTLE(3)) u_s3 (
    .clk(clk), .rst(rst[1]),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]), .cmd_op(cmd_op[1]), .cmd_chain(cmd_chain[1]),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_op(alu_op[1]),
    .alu_out(alu_out[1]), .alu_ovf(alu_ovf[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_data(rsp_data[1]), .rsp_ovf(rsp_ovf[1]), .rsp_err(rsp_err[1]),
`ifdef ALU_SEQ_STICKY_OVF_EN
    .ovf_sticky(ovf_sticky[1]), .ovf_clr(ovf_clr[1]),
`endif
    .busy(busy[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // All outputs at their reset values
  task automatic chk_reset(input int d);
    chk("rst_cmd_ready", 32'(cmd_ready[d]), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
    chk("rst_busy",      32'(busy[d]),      32'd0);
    chk("rst_rsp_data",  32'(rsp_data[d]),  32'd0);
    chk("rst_rsp_ovf",   32'(rsp_ovf[d]),   32'd0);
    chk("rst_rsp_err",   32'(rsp_err[d]),   32'd0);
    chk("rst_alu_a",     32'(alu_a[d]),     32'd0);
    chk("rst_alu_b",     32'(alu_b[d]),     32'd0);
    chk("rst_alu_op",    32'(alu_op[d]),    32'd0);
  endtask

  // Issue one command, measure edges from accept to rsp_valid, check and drain the response.
  task automatic run_op(input int d, input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] op, input logic chain,
                        input logic [3:0] exp_data, input logic exp_ovf, input logic exp_err,
                        input int exp_lat);
    int lat;
    chk("pre_cmd_ready", 32'(cmd_ready[d]), 32'd1);
    cmd_valid[d] = 1'b1;
    cmd_a[d]     = a;
    cmd_b[d]     = b;
    cmd_op[d]    = op;
    cmd_chain[d] = chain;
    @(posedge clk); #1;
    cmd_valid[d] = 1'b0;
    lat = 0;
    while (!rsp_valid[d] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency",  32'(lat),         32'(exp_lat));
    chk("rsp_data", 32'(rsp_data[d]), 32'(exp_data));
    chk("rsp_ovf",  32'(rsp_ovf[d]),  32'(exp_ovf));
    chk("rsp_err",  32'(rsp_err[d]),  32'(exp_err));
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
    chk("post_rsp_valid", 32'(rsp_valid[d]), 32'd0);
    chk("post_cmd_ready", 32'(cmd_ready[d]), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; cmd_valid[i] = 1'b0; cmd_chain[i] = 1'b0; rsp_ready[i] = 1'b0;
      cmd_a[i] = '0; cmd_b[i] = '0; cmd_op[i] = '0;
`ifdef ALU_SEQ_STICKY_OVF_EN
      ovf_clr[i] = 1'b0;
`endif
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    chk_reset(0);
    chk_reset(1);

    // ---- SETTLE=1 ----
    run_op(0, 4'h9, 4'h8, 3'b000, 1'b0, 4'h1, 1'b1, 1'b0, 1);   // signed overflow
    run_op(0, 4'h5, 4'h5, 3'b001, 1'b0, 4'hF, 1'b0, 1'b0, 1);   // ALU ovf masked
    run_op(0, 4'h5, 4'h6, 3'b001, 1'b0, 4'h0, 1'b0, 1'b0, 1);
    run_op(0, 4'h3, 4'h2, 3'b101, 1'b0, 4'h0, 1'b0, 1'b1, 0);   // illegal
    chk("illegal_keeps_alu_op", 32'(alu_op[0]), 32'd1);
    chk("illegal_keeps_alu_a",  32'(alu_a[0]),  32'h5);
    chk("illegal_keeps_alu_b",  32'(alu_b[0]),  32'h6);

    run_op(0, 4'h3, 4'h4, 3'b000, 1'b0, 4'h7, 1'b0, 1'b0, 1);
    run_op(0, 4'h1, 4'h1, 3'b110, 1'b0, 4'h0, 1'b0, 1'b1, 0);   // err leaves acc alone
    run_op(0, 4'hF, 4'hA, 3'b010, 1'b1, 4'h3, 1'b0, 1'b0, 1);   // 7>>1 via chain

    // Response back-pressure with a competing command held on the input
    cmd_valid[0] = 1'b1; cmd_a[0] = 4'h2; cmd_b[0] = 4'h3; cmd_op[0] = 3'b000; cmd_chain[0] = 1'b0;
    @(posedge clk); #1;
    cmd_a[0] = 4'hF; cmd_b[0] = 4'hF; cmd_op[0] = 3'b100;
    @(posedge clk); #1;
    chk("bp_rsp_valid", 32'(rsp_valid[0]), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_rsp_data",  32'(rsp_data[0]),  32'h5);
      chk("bp_rsp_valid", 32'(rsp_valid[0]), 32'd1);
      chk("bp_cmd_ready", 32'(cmd_ready[0]), 32'd0);
      chk("bp_busy",      32'(busy[0]),      32'd1);
    end
    chk("bp_alu_a_held", 32'(alu_a[0]), 32'h2);
    cmd_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0;
    chk("bp_release_cmd_ready", 32'(cmd_ready[0]), 32'd1);
    run_op(0, 4'hF, 4'h1, 3'b000, 1'b1, 4'h6, 1'b0, 1'b0, 1);   // acc=5 kept
    run_op(0, 4'h0, 4'h3, 3'b011, 1'b1, 4'hD, 1'b0, 1'b0, 1);   // -3
    run_op(0, 4'h0, 4'h8, 3'b011, 1'b0, 4'h8, 1'b0, 1'b0, 1);   // -8: ALU ovf masked
    run_op(0, 4'hC, 4'hA, 3'b100, 1'b0, 4'h8, 1'b0, 1'b0, 1);

    // ---- SETTLE=3 ----
    run_op(1, 4'h9, 4'h8, 3'b000, 1'b0, 4'h1, 1'b1, 1'b0, 3);
    cmd_valid[1] = 1'b1; cmd_a[1] = 4'h6; cmd_b[1] = 4'h1; cmd_op[1] = 3'b000; cmd_chain[1] = 1'b0;
    @(posedge clk); #1;
    cmd_valid[1] = 1'b0;
    chk("issue_busy", 32'(busy[1]), 32'd1);
    @(posedge clk); #3;
    rst[1] = 1'b1;
    #1;
    chk_reset(1);
    #2;
    rst[1] = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (rsp_valid[1]) seen++;
    end
    chk("abort_no_rsp", 32'(seen), 32'd0);
    run_op(1, 4'hF, 4'h2, 3'b000, 1'b1, 4'h2, 1'b0, 1'b0, 3);   // acc cleared by reset
    run_op(1, 4'h6, 4'h1, 3'b000, 1'b0, 4'h7, 1'b0, 1'b0, 3);
    run_op(1, 4'h0, 4'h1, 3'b000, 1'b1, 4'h8, 1'b1, 1'b0, 3);   // 7+1 overflows
    run_op(1, 4'h2, 4'h2, 3'b111, 1'b0, 4'h0, 1'b0, 1'b1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
